sram_ctrl: RTL and testbench
============================

# sram_ctrl

Multi-cycle controller between the memory-access stage and off-chip asynchronous SRAM. It accepts the stage's word-aligned read/write strobe, address, byte enables and write data, and runs an SRAM cycle with a programmable number of wait states. It returns registered read data to the stage's `mem_access_data_i` input. It also raises `stall` so the pipeline holds the request stable until the access completes.

## Interface
- `WAIT_CYCLES`, default 1: extra SRAM access cycles beyond the first (0..15).
- `ADDR_W`, default 20: SRAM word-address width.
- `clk` in 1: pipeline clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_access_read` in 1: read request from the memory stage.
- `mem_access_write` in 1: write request from the memory stage.
- `mem_access_addr` in 32: byte address; bits [ADDR_W+1:2] are used.
- `mem_access_wdata` in 32: lane-replicated write data.
- `mem_access_byte_en` in 4: active-high byte lanes.
- `alignment_err` in 1: request is misaligned; it must not be issued.
- `mem_access_rdata` out 32: last completed read word. Reset value 0.
- `stall` out 1: pipeline hold. Reset value 0.
- `sram_addr` out ADDR_W: word address. Reset value 0.
- `sram_wdata` out 32: data driven to SRAM. Reset value 0.
- `sram_data_oe` out 1: tristate enable for `sram_wdata`. Reset value 0.
- `sram_rdata` in 32: data from SRAM.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` out 1 each: active-low strobes. Reset value 1.
- `sram_be_n` out 4: active-low byte lanes. Reset value 4'hF.

## Operation
- **States.** IDLE, ACCESS, DONE. A 4-bit wait counter `cnt` drives ACCESS.
- **Request.** `req = (mem_access_read | mem_access_write) & ~alignment_err`. If read and write are both high, the write wins.
- **IDLE.**
  - On `req`: latch op, address, byte enables and write data; set `cnt = WAIT_CYCLES`; go to ACCESS.
  - `stall = req`, combinationally, in the same cycle.
- **ACCESS.**
  - Drive `sram_ce_n=0`, `sram_addr`, and `sram_be_n = ~byte_en`.
  - Read: `sram_oe_n=0`.
  - Write: `sram_we_n=0`, `sram_data_oe=1`.
  - If `cnt != 0`, decrement. If `cnt == 0`, go to DONE; for a read, also load `mem_access_rdata <= sram_rdata` on that edge.
  - `stall = 1`.
- **DONE.**
  - `stall = 0`, so the pipeline advances on this edge.
  - `sram_ce_n`, `sram_oe_n` and `sram_we_n` are all 1.
  - For a write, address, `sram_wdata` and `sram_data_oe` are held one more cycle (data hold time).
  - Always go to IDLE next.
- **Lane handling.** Byte-enable and lane handling belong to the memory stage; this block passes lanes through unmodified.
- **Rejected requests.** If `alignment_err` is set in IDLE, no SRAM cycle starts, `stall = 0`, and `mem_access_rdata` is unchanged.
- **Requests outside IDLE.** Request inputs are ignored in ACCESS and DONE; only the latched copy is used.
- **Reset.** Reset at any point, including mid-ACCESS, returns to IDLE immediately and forces every output to its reset value; all strobes deassert asynchronously.

## Timing
- With W = `WAIT_CYCLES`, a miss access takes W+3 cycles:
  - cycle 0: IDLE, request seen, `stall`=1;
  - cycles 1..W+1: ACCESS, `stall`=1;
  - cycle W+2: DONE, `stall`=0.
- `stall` is therefore high for W+2 cycles.
- Read data is valid on `mem_access_rdata` from cycle W+2 and holds until the next read completes.
- Back-to-back requests: the earliest next IDLE acceptance is cycle W+3.
- `sram_oe_n` / `sram_we_n` are low for exactly W+1 cycles.
- Write data and address remain stable one cycle after `sram_we_n` rises.

## Configuration
- `SRAM_CTRL_RDBUF_EN` defined:
  - The block keeps `last_addr[ADDR_W-1:0]` and `last_valid`.
  - `last_valid` is set on each read completion (DONE) and cleared by reset or by the start of any write.
  - A read in IDLE with `last_valid` set and a matching word address is a hit. On a hit, no SRAM cycle is started, `stall = 0`, and `mem_access_rdata` already holds the word. It completes in 1 cycle.
- `SRAM_CTRL_RDBUF_EN` undefined: every read takes the full W+3 sequence.

## Test plan
- **Read, W=1.** Addr 0x0000_0010, `sram_rdata`=0xDEAD_BEEF → `sram_addr`=4 and `sram_oe_n` low in cycles 1–2; `stall` high in cycles 0–2; `mem_access_rdata`=0xDEAD_BEEF in cycle 3.
- **Write, W=0.** Addr 0x0000_0008, be=4'b1100, data 0x1234_1234 → `sram_we_n` low only in cycle 1; `sram_be_n`=4'b0011; data held with `sram_data_oe`=1 in cycle 2; `stall` high in cycles 0–1.
- **Misaligned request.** Read with `alignment_err`=1 → `stall` stays 0; `sram_ce_n` stays 1; `mem_access_rdata` unchanged.
- **Reset mid-access.** W=3 read; assert `rst_n`=0 in cycle 2 → strobes high and `stall`=0 without waiting for a clock edge; after release, the next read runs the full W+3 sequence.
- **Read buffer (with `SRAM_CTRL_RDBUF_EN`).**
  - Read 0x20, then read 0x20 again → second read has `stall`=0 and no `sram_ce_n` assertion.
  - Write 0x40, then read 0x20 → full SRAM cycle.
- **Simultaneous read and write.** Both high at addr 0x4 → write cycle issued (`sram_we_n` low); `sram_oe_n` stays 1.

Source files
------------

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
//
// Multi-cycle controller between the memory-access stage and an off-chip
// asynchronous SRAM. A request accepted in IDLE is latched and run as one
// SRAM cycle lasting WAIT_CYCLES+1 clocks (ACCESS). This is followed by one
// DONE cycle that releases the pipeline and, for writes, holds the address
// and data. While the access is in flight, stall keeps the pipeline frozen.
//
// Optional feature macro: SRAM_CTRL_RDBUF_EN
//   When defined, the controller remembers the word address of the last
//   completed read. A repeated read of that word then completes in IDLE with
//   no SRAM cycle and no stall.
//
// Parameters
//   WAIT_CYCLES  extra SRAM access cycles beyond the first (0..15)
//   ADDR_W       SRAM word-address width
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_access_read       read request from the memory stage
//   mem_access_write      write request (wins over read)
//   mem_access_addr       byte address, bits [ADDR_W+1:2] used
//   mem_access_wdata      lane-replicated write data
//   mem_access_byte_en    active-high byte lanes
//   alignment_err         misaligned request, never issued
//   mem_access_rdata      last completed read word
//   stall                 pipeline hold
//   sram_addr             SRAM word address
//   sram_wdata            SRAM write data
//   sram_data_oe          tristate enable for sram_wdata
//   sram_rdata            SRAM read data
//   sram_ce_n/oe_n/we_n   active-low SRAM strobes
//   sram_be_n             active-low SRAM byte lanes
// ---------------------------------------------------------------------------
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_access_read,
    input  logic              mem_access_write,
    input  logic [31:0]       mem_access_addr,
    input  logic [31:0]       mem_access_wdata,
    input  logic [3:0]        mem_access_byte_en,
    input  logic              alignment_err,
    output logic [31:0]       mem_access_rdata,
    output logic              stall,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic              sram_data_oe,
    input  logic [31:0]       sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]        state_q,    state_d;
    logic [3:0]        cnt_q,      cnt_d;
    logic              is_write_q, is_write_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [3:0]        be_q,       be_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic [31:0]       rdata_q,    rdata_d;

    logic              req;
    logic              rd_hit;
    logic [ADDR_W-1:0] req_addr;

    // Byte offset and address bits above the SRAM range are not used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_access_addr[31:ADDR_W+2], mem_access_addr[1:0]};

    assign req      = (mem_access_read | mem_access_write) & ~alignment_err;
    assign req_addr = mem_access_addr[ADDR_W+1:2];

`ifdef SRAM_CTRL_RDBUF_EN
    logic [ADDR_W-1:0] last_addr_q,  last_addr_d;
    logic              last_valid_q, last_valid_d;

    // A hit is a read-only request. A simultaneous write is treated as a write.
    assign rd_hit = req & mem_access_read & ~mem_access_write &
                    last_valid_q & (last_addr_q == req_addr);
`else
    assign rd_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
`ifdef SRAM_CTRL_RDBUF_EN
        last_addr_d  = last_addr_q;
        last_valid_d = last_valid_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req && !rd_hit) begin
                    state_d    = S_ACCESS;
                    cnt_d      = WAIT_INIT;
                    is_write_d = mem_access_write;
                    addr_d     = req_addr;
                    be_d       = mem_access_byte_en;
                    wdata_d    = mem_access_wdata;
`ifdef SRAM_CTRL_RDBUF_EN
                    if (mem_access_write) begin
                        last_valid_d = 1'b0;
                    end
`endif
                end
            end
            S_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_DONE;
                    // Sample the SRAM on the final edge of the strobe window.
                    if (!is_write_q) begin
                        rdata_d = sram_rdata;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef SRAM_CTRL_RDBUF_EN
                if (!is_write_q) begin
                    last_valid_d = 1'b1;
                    last_addr_d  = addr_q;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
`ifdef SRAM_CTRL_RDBUF_EN
            last_addr_q  <= '0;
            last_valid_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
`ifdef SRAM_CTRL_RDBUF_EN
            last_addr_q  <= last_addr_d;
            last_valid_q <= last_valid_d;
`endif
        end
    end

    // All outputs are decoded from reset-cleared state. This means asserting
    // rst_n drops every strobe immediately. stall is also gated by rst_n,
    // because in IDLE it follows the request inputs combinationally.
    always_comb begin
        stall = 1'b0;
        case (state_q)
            S_IDLE:   stall = req & ~rd_hit;
            S_ACCESS: stall = 1'b1;
            default:  stall = 1'b0;
        endcase
        stall = stall & rst_n;
    end

    assign sram_ce_n    = (state_q != S_ACCESS);
    assign sram_oe_n    = !((state_q == S_ACCESS) && !is_write_q);
    assign sram_we_n    = !((state_q == S_ACCESS) && is_write_q);
    // Write data stays driven through DONE to meet the SRAM data hold time.
    assign sram_data_oe = is_write_q && ((state_q == S_ACCESS) || (state_q == S_DONE));
    assign sram_be_n    = (state_q == S_ACCESS) ? ~be_q : 4'hF;
    assign sram_addr    = addr_q;
    assign sram_wdata   = wdata_q;

    assign mem_access_rdata = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl
//
// Directed bench for sram_ctrl. Three instances share the request inputs and
// the SRAM read bus:
//   u_w0  WAIT_CYCLES=0
//   u_w1  WAIT_CYCLES=1
//   u_w3  WAIT_CYCLES=3
// Each directed step checks the instance whose latency it targets. Between
// steps, the bench idles long enough for every instance to return to IDLE.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  be = 4'h0;
    logic        ae = 1'b0;
    logic [31:0] srd = 32'd0;

    logic [31:0] rdata   [3];
    logic        stall   [3];
    logic [19:0] saddr   [3];
    logic [31:0] swdata  [3];
    logic        data_oe [3];
    logic        ce_n    [3];
    logic        oe_n    [3];
    logic        we_n    [3];
    logic [3:0]  be_n    [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_ctrl #(.WAIT_CYCLES(0), .ADDR_W(20)) u_w0 (
        .clk(clk), .rst_n(rst_n),
        .mem_access_read(rd), .mem_access_write(wr),
        .mem_access_addr(addr), .mem_access_wdata(wdata),
        .mem_access_byte_en(be), .alignment_err(ae),
        .mem_access_rdata(rdata[0]), .stall(stall[0]),
        .sram_addr(saddr[0]), .sram_wdata(swdata[0]),
        .sram_data_oe(data_oe[0]), .sram_rdata(srd),
        .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]),
        .sram_we_n(we_n[0]), .sram_be_n(be_n[0])
    );

    sram_ctrl #(.WAIT_CYCLES(1), .ADDR_W(20)) u_w1 (
        .clk(clk), .rst_n(rst_n),
        .mem_access_read(rd), .mem_access_write(wr),
        .mem_access_addr(addr), .mem_access_wdata(wdata),
        .mem_access_byte_en(be), .alignment_err(ae),
        .mem_access_rdata(rdata[1]), .stall(stall[1]),
        .sram_addr(saddr[1]), .sram_wdata(swdata[1]),
        .sram_data_oe(data_oe[1]), .sram_rdata(srd),
        .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]),
        .sram_we_n(we_n[1]), .sram_be_n(be_n[1])
    );

    sram_ctrl #(.WAIT_CYCLES(3), .ADDR_W(20)) u_w3 (
        .clk(clk), .rst_n(rst_n),
        .mem_access_read(rd), .mem_access_write(wr),
        .mem_access_addr(addr), .mem_access_wdata(wdata),
        .mem_access_byte_en(be), .alignment_err(ae),
        .mem_access_rdata(rdata[2]), .stall(stall[2]),
        .sram_addr(saddr[2]), .sram_wdata(swdata[2]),
        .sram_data_oe(data_oe[2]), .sram_rdata(srd),
        .sram_ce_n(ce_n[2]), .sram_oe_n(oe_n[2]),
        .sram_we_n(we_n[2]), .sram_be_n(be_n[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge, where outputs are sampled.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rd = 1'b0; wr = 1'b0; ae = 1'b0;
        repeat (n) cyc();
    endtask

    initial begin
        // Reset values while reset is asserted.
        #2;
        chk("rst stall",   32'(stall[1]),   32'd0);
        chk("rst ce_n",    32'(ce_n[1]),    32'd1);
        chk("rst oe_n",    32'(oe_n[1]),    32'd1);
        chk("rst we_n",    32'(we_n[1]),    32'd1);
        chk("rst be_n",    32'(be_n[1]),    32'hF);
        chk("rst addr",    32'(saddr[1]),   32'd0);
        chk("rst wdata",   swdata[1],       32'd0);
        chk("rst data_oe", 32'(data_oe[1]), 32'd0);
        chk("rst rdata",   rdata[1],        32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // Read, W=1: stall high for cycles 0-2, oe_n low for cycles 1-2,
        // and the data appears in cycle 3.
        rd = 1'b1; addr = 32'h0000_0010; srd = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            mid();
            chk($sformatf("rd_w1 stall c%0d", c), 32'(stall[1]), 32'(c < 3));
            chk($sformatf("rd_w1 oe_n c%0d", c),  32'(oe_n[1]),  32'(!(c == 1 || c == 2)));
            chk($sformatf("rd_w1 ce_n c%0d", c),  32'(ce_n[1]),  32'(!(c == 1 || c == 2)));
            if (c == 1 || c == 2) chk($sformatf("rd_w1 addr c%0d", c), 32'(saddr[1]), 32'd4);
            if (c == 3) chk("rd_w1 rdata", rdata[1], 32'hDEAD_BEEF);
            cyc();
        end
        idle(8);

        // Write, W=0: we_n is low only in cycle 1, and the data is held with
        // oe asserted in cycle 2.
        wr = 1'b1; addr = 32'h0000_0008; be = 4'b1100; wdata = 32'h1234_1234;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin wr = 1'b0; end
            mid();
            chk($sformatf("wr_w0 stall c%0d", c), 32'(stall[0]), 32'(c < 2));
            chk($sformatf("wr_w0 we_n c%0d", c),  32'(we_n[0]),  32'(c != 1));
            chk($sformatf("wr_w0 data_oe c%0d", c), 32'(data_oe[0]), 32'(c == 1 || c == 2));
            if (c == 1) chk("wr_w0 be_n", 32'(be_n[0]), 32'h3);
            if (c == 1 || c == 2) begin
                chk($sformatf("wr_w0 wdata c%0d", c), swdata[0], 32'h1234_1234);
                chk($sformatf("wr_w0 addr c%0d", c), 32'(saddr[0]), 32'd2);
            end
            cyc();
        end
        idle(8);

        // Misaligned read: the request is never issued.
        rd = 1'b1; ae = 1'b1; addr = 32'h0000_0013; srd = 32'hCAFE_F00D;
        for (int c = 0; c < 3; c++) begin
            mid();
            chk($sformatf("mis stall c%0d", c), 32'(stall[1]), 32'd0);
            chk($sformatf("mis ce_n c%0d", c),  32'(ce_n[1]),  32'd1);
            chk($sformatf("mis rdata c%0d", c), rdata[1],      32'hDEAD_BEEF);
            cyc();
        end
        idle(8);

        // Reset mid-access on W=3. Reset is asserted in cycle 2, off the clock edge.
        rd = 1'b1; addr = 32'h0000_0030; srd = 32'h0BAD_F00D;
        mid();
        chk("rstmid stall c0", 32'(stall[2]), 32'd1);
        cyc();
        mid();
        chk("rstmid ce_n c1", 32'(ce_n[2]), 32'd0);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("rstmid stall", 32'(stall[2]), 32'd0);
        chk("rstmid ce_n",  32'(ce_n[2]),  32'd1);
        chk("rstmid oe_n",  32'(oe_n[2]),  32'd1);
        chk("rstmid rdata", rdata[2],      32'd0);
        chk("rstmid addr",  32'(saddr[2]), 32'd0);
        rd = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        rd = 1'b1; addr = 32'h0000_0030; srd = 32'h5A5A_A5A5;
        for (int c = 0; c < 6; c++) begin
            mid();
            chk($sformatf("postrst stall c%0d", c), 32'(stall[2]), 32'(c < 5));
            chk($sformatf("postrst oe_n c%0d", c),  32'(oe_n[2]),  32'(!(c >= 1 && c <= 4)));
            if (c == 5) chk("postrst rdata", rdata[2], 32'h5A5A_A5A5);
            cyc();
        end
        idle(8);

        // Simultaneous read and write: the write wins.
        rd = 1'b1; wr = 1'b1; addr = 32'h0000_0004; wdata = 32'h0F0F_0F0F; be = 4'hF;
        for (int c = 0; c < 4; c++) begin
            mid();
            chk($sformatf("rw we_n c%0d", c), 32'(we_n[1]), 32'(!(c == 1 || c == 2)));
            chk($sformatf("rw oe_n c%0d", c), 32'(oe_n[1]), 32'd1);
            if (c == 1) chk("rw addr", 32'(saddr[1]), 32'd1);
            cyc();
        end
        idle(8);

        // Repeated read of the same word.
        rd = 1'b1; addr = 32'h0000_0020; srd = 32'h1111_2222;
        repeat (4) cyc();
`ifdef SRAM_CTRL_RDBUF_EN
        // The second read hits the buffer: no stall and no chip enable.
        for (int c = 0; c < 2; c++) begin
            mid();
            chk($sformatf("hit stall c%0d", c), 32'(stall[1]), 32'd0);
            chk($sformatf("hit ce_n c%0d", c),  32'(ce_n[1]),  32'd1);
            chk($sformatf("hit rdata c%0d", c), rdata[1],      32'h1111_2222);
            cyc();
        end
        idle(8);
        // A write clears the buffer, so the next read runs a full SRAM cycle.
        wr = 1'b1; addr = 32'h0000_0040; wdata = 32'h7777_7777;
        repeat (4) cyc();
        idle(8);
        rd = 1'b1; addr = 32'h0000_0020; srd = 32'h3333_4444;
        mid();
        chk("inval stall c0", 32'(stall[1]), 32'd1);
        cyc();
        mid();
        chk("inval ce_n c1", 32'(ce_n[1]), 32'd0);
        cyc();
        cyc();
        mid();
        chk("inval rdata c3", rdata[1], 32'h3333_4444);
        cyc();
`else
        // Without the buffer, the repeated read is a full SRAM cycle again.
        srd = 32'h3333_4444;
        mid();
        chk("rerd stall c0", 32'(stall[1]), 32'd1);
        cyc();
        mid();
        chk("rerd ce_n c1", 32'(ce_n[1]), 32'd0);
        cyc();
        cyc();
        mid();
        chk("rerd rdata c3", rdata[1], 32'h3333_4444);
        cyc();
`endif
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
